shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_shift_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter
//   Two requesters share a single 8-bit barrel shifter. A round-robin
//   arbiter picks one valid request per cycle. The chosen operands are
//   shifted and captured in a one-deep result register, which drains
//   through a valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   reqN_valid / reqN_ready    requester N handshake (N = 0, 1)
//   reqN_din                   8-bit operand
//   reqN_shamt                 shift amount 0..7
//   reqN_lr                    1 = shift left, 0 = shift right
//   reqN_al                    right-shift fill: 1 = sign bit, 0 = zero
//   out_valid / out_ready      result handshake
//   out_data, out_id           result value and index of the issuing requester
//   grant_cnt0, grant_cnt1     wrapping counts of accepted operations

// barrel_shifter
//   Purely combinational 8-bit shifter built from log2 stages (1, 2, 4).
//   Left shifts fill with zero. Right shifts fill with din[7] when al=1,
//   and with zero otherwise.
module barrel_shifter (
  input  logic [7:0] din,
  input  logic [2:0] shamt,
  input  logic       lr,
  input  logic       al,
  output logic [7:0] dout
);

  logic       fill;
  logic [7:0] stage_val;

  // The sign bit of the original operand is the fill for every stage.
  // Composing arithmetic shifts by 1, 2 and 4 therefore equals one
  // arithmetic shift by their sum.
  assign fill = al & din[7];

  always_comb begin
    stage_val = din;
    for (int i = 0; i < 3; i++) begin
      if (shamt[i]) begin
        if (lr) begin
          stage_val = stage_val << (1 << i);
        end else begin
          stage_val = (stage_val >> (1 << i)) |
                      (fill ? ~(8'hFF >> (1 << i)) : 8'h00);
        end
      end
    end
  end

  assign dout = stage_val;

endmodule

module shift_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_din,
  input  logic [2:0] req0_shamt,
  input  logic       req0_lr,
  input  logic       req0_al,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_din,
  input  logic [2:0] req1_shamt,
  input  logic       req1_lr,
  input  logic       req1_al,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_id,
  output logic [7:0] grant_cnt0,
  output logic [7:0] grant_cnt1
);

  logic       out_valid_reg, out_valid_next;
  logic [7:0] out_data_reg,  out_data_next;
  logic       out_id_reg,    out_id_next;
  logic       last_served_reg, last_served_next;
  logic [7:0] grant_cnt0_reg, grant_cnt0_next;
  logic [7:0] grant_cnt1_reg, grant_cnt1_next;

  logic       grant0;
  logic       grant1;
  logic       can_accept;
  logic       accept;

  logic [7:0] sh_din;
  logic [2:0] sh_shamt;
  logic       sh_lr;
  logic       sh_al;
  logic [7:0] sh_dout;

  // Round-robin: a lone requester always wins. Under contention the
  // requester that was not served last wins. last_served resets to 1,
  // so requester 0 wins the first contention.
  assign grant0 = req0_valid & (~req1_valid |  last_served_reg);
  assign grant1 = req1_valid & (~req0_valid | ~last_served_reg);

  // The result register can take a new value when it is empty or is
  // being drained in this same cycle.
  assign can_accept = ~out_valid_reg | out_ready;
  assign accept     = (grant0 | grant1) & can_accept;

  // rst_n gates the readies so that no requester sees a handshake while
  // reset is held.
  assign req0_ready = rst_n & grant0 & can_accept;
  assign req1_ready = rst_n & grant1 & can_accept;

  // Operand mux in front of the single shared shifter. grant1 is the
  // selector, because at most one grant is ever active.
  always_comb begin
    sh_din   = req0_din;
    sh_shamt = req0_shamt;
    sh_lr    = req0_lr;
    sh_al    = req0_al;
    if (grant1) begin
      sh_din   = req1_din;
      sh_shamt = req1_shamt;
      sh_lr    = req1_lr;
      sh_al    = req1_al;
    end
  end

  barrel_shifter u_shifter (
    .din   (sh_din),
    .shamt (sh_shamt),
    .lr    (sh_lr),
    .al    (sh_al),
    .dout  (sh_dout)
  );

  always_comb begin
    out_valid_next   = out_valid_reg;
    out_data_next    = out_data_reg;
    out_id_next      = out_id_reg;
    last_served_next = last_served_reg;
    grant_cnt0_next  = grant_cnt0_reg;
    grant_cnt1_next  = grant_cnt1_reg;
    if (accept) begin
      // Accepting a request also covers a pop in the same cycle: the new
      // result replaces the old one and out_valid stays high.
      out_valid_next   = 1'b1;
      out_data_next    = sh_dout;
      out_id_next      = grant1;
      last_served_next = grant1;
      if (grant1) begin
        grant_cnt1_next = grant_cnt1_reg + 8'd1;
      end else begin
        grant_cnt0_next = grant_cnt0_reg + 8'd1;
      end
    end else if (out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg   <= 1'b0;
      out_data_reg    <= 8'h00;
      out_id_reg      <= 1'b0;
      last_served_reg <= 1'b1;
      grant_cnt0_reg  <= 8'h00;
      grant_cnt1_reg  <= 8'h00;
    end else begin
      out_valid_reg   <= out_valid_next;
      out_data_reg    <= out_data_next;
      out_id_reg      <= out_id_next;
      last_served_reg <= last_served_next;
      grant_cnt0_reg  <= grant_cnt0_next;
      grant_cnt1_reg  <= grant_cnt1_next;
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_id     = out_id_reg;
  assign grant_cnt0 = grant_cnt0_reg;
  assign grant_cnt1 = grant_cnt1_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter
//   Directed scenarios followed by randomized traffic. A reference model
//   runs on the falling edge. It predicts the readies, out_valid and the
//   counters, and it queues the expected result for every accepted
//   request. A separate monitor compares each presented result against
//   the head of that queue.
module tb_shift_arbiter;

  logic       clk;
  logic       rst_n;
  logic       r0_valid, r1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] r0_din, r1_din;
  logic [2:0] r0_shamt, r1_shamt;
  logic       r0_lr, r1_lr, r0_al, r1_al;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_id;
  logic [7:0] grant_cnt0, grant_cnt1;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic [7:0] data;
    logic       id;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  bit       m_valid;
  bit       m_last;
  bit [7:0] m_cnt0;
  bit [7:0] m_cnt1;

  shift_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (r0_valid),
    .req0_ready (req0_ready),
    .req0_din   (r0_din),
    .req0_shamt (r0_shamt),
    .req0_lr    (r0_lr),
    .req0_al    (r0_al),
    .req1_valid (r1_valid),
    .req1_ready (req1_ready),
    .req1_din   (r1_din),
    .req1_shamt (r1_shamt),
    .req1_lr    (r1_lr),
    .req1_al    (r1_al),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input int sh,
                                           input bit lr, input bit al);
    logic [15:0]       wide;
    logic signed [7:0] s;
    if (lr) begin
      wide = {8'h00, d} << sh;
      return wide[7:0];
    end
    if (al) begin
      s = d;
      return s >>> sh;
    end
    return d >> sh;
  endfunction

  // Reference model: arbitration and result prediction
  always @(negedge clk) begin
    bit can, g0, g1, id;
    exp_t e;
    if (!rst_n) begin
      m_valid = 0;
      m_last  = 1;
      m_cnt0  = 0;
      m_cnt1  = 0;
      exp_q.delete();
      check("rst_ready0", 32'(req0_ready), 32'd0);
      check("rst_ready1", 32'(req1_ready), 32'd0);
      check("rst_valid",  32'(out_valid),  32'd0);
      check("rst_cnt0",   32'(grant_cnt0), 32'd0);
      check("rst_cnt1",   32'(grant_cnt1), 32'd0);
    end else begin
      can = !m_valid || out_ready;
      g0  = r0_valid && (!r1_valid || m_last == 1'b1);
      g1  = r1_valid && (!r0_valid || m_last == 1'b0);
      check("ready0",    32'(req0_ready), 32'(g0 && can));
      check("ready1",    32'(req1_ready), 32'(g1 && can));
      check("out_valid", 32'(out_valid),  32'(m_valid));
      check("cnt0",      32'(grant_cnt0), 32'(m_cnt0));
      check("cnt1",      32'(grant_cnt1), 32'(m_cnt1));
      if ((g0 || g1) && can) begin
        id     = g1;
        e.id   = id;
        e.data = id ? ref_shift(r1_din, int'(r1_shamt), r1_lr, r1_al)
                    : ref_shift(r0_din, int'(r0_shamt), r0_lr, r0_al);
        exp_q.push_back(e);
        m_last  = id;
        m_valid = 1;
        if (id) m_cnt1 = m_cnt1 + 8'd1;
        else    m_cnt0 = m_cnt0 + 8'd1;
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Monitor: compares every presented result with the oldest expected one
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        check("result_expected", 32'd0, 32'd1);
      end else begin
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
        check("out_id",   32'(out_id),   32'(exp_q[0].id));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd0(input bit v);
    r0_valid = v;
    r0_din   = 8'($urandom);
    r0_shamt = 3'($urandom);
    r0_lr    = 1'($urandom);
    r0_al    = 1'($urandom);
  endtask

  task automatic rnd1(input bit v);
    r1_valid = v;
    r1_din   = 8'($urandom);
    r1_shamt = 3'($urandom);
    r1_lr    = 1'($urandom);
    r1_al    = 1'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  logic [7:0] held;

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    rnd0(0);
    rnd1(0);
    #3;
    check("init_valid", 32'(out_valid),  32'd0);
    check("init_data",  32'(out_data),   32'd0);
    check("init_id",    32'(out_id),     32'd0);
    r0_valid = 1'b1;
    #1;
    check("init_ready0", 32'(req0_ready), 32'd0);
    r0_valid = 1'b0;
    step();
    step();
    rst_n = 1'b1;

    // Single arithmetic right shift: 0x96 >>> 2 = 0xE5
    r0_valid = 1; r0_din = 8'h96; r0_shamt = 3'd2; r0_lr = 0; r0_al = 1;
    step();
    r0_valid = 0;
    check("ars_valid", 32'(out_valid),  32'd1);
    check("ars_data",  32'(out_data),   32'hE5);
    check("ars_id",    32'(out_id),     32'd0);
    check("ars_cnt0",  32'(grant_cnt0), 32'd1);

    // Left shift 0x96 << 3 = 0xB0, then logical right 0x96 >> 1 = 0x4B
    r1_valid = 1; r1_din = 8'h96; r1_shamt = 3'd3; r1_lr = 1; r1_al = 0;
    step();
    check("shl_data", 32'(out_data), 32'hB0);
    check("shl_id",   32'(out_id),   32'd1);
    r1_shamt = 3'd1; r1_lr = 0; r1_al = 0;
    step();
    check("lsr_data", 32'(out_data), 32'h4B);
    check("lsr_id",   32'(out_id),   32'd1);
    r1_valid = 0;
    step();

    // Contention straight after reset: ids alternate 0,1,0,1
    do_reset();
    for (int i = 0; i < 4; i++) begin
      rnd0(1);
      rnd1(1);
      step();
      check("rr_id", 32'(out_id), 32'(i % 2));
    end
    check("rr_cnt0", 32'(grant_cnt0), 32'd2);
    check("rr_cnt1", 32'(grant_cnt1), 32'd2);

    // Backpressure with both requesters valid
    out_ready = 0;
    held = out_data;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_data",   32'(out_data),   32'(held));
      check("bp_id",     32'(out_id),     32'd1);
      check("bp_ready0", 32'(req0_ready), 32'd0);
      check("bp_ready1", 32'(req1_ready), 32'd0);
    end
    out_ready = 1;
    #1;
    check("bp_release_ready0", 32'(req0_ready), 32'd1);
    step();
    check("bp_pop_valid", 32'(out_valid),  32'd1);
    check("bp_pop_id",    32'(out_id),     32'd0);
    check("bp_pop_cnt0",  32'(grant_cnt0), 32'd3);

    // Reset between edges while a result is held
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid",  32'(out_valid),  32'd0);
    check("async_cnt0",   32'(grant_cnt0), 32'd0);
    check("async_cnt1",   32'(grant_cnt1), 32'd0);
    check("async_ready0", 32'(req0_ready), 32'd0);
    check("async_ready1", 32'(req1_ready), 32'd0);
    step();
    rst_n = 1'b1;

    // Counter wrap after 256 accepts of requester 0
    r1_valid = 0;
    for (int i = 0; i < 256; i++) begin
      rnd0(1);
      step();
      if (i == 254) check("wrap_255", 32'(grant_cnt0), 32'd255);
    end
    r0_valid = 0;
    check("wrap_0", 32'(grant_cnt0), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rnd0($urandom_range(0, 3) != 0);
      rnd1($urandom_range(0, 2) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    // Drain the result register
    r0_valid  = 0;
    r1_valid  = 0;
    out_ready = 1;
    step();
    step();
    step();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
